// File: rtl/cpc_ram_paging_ctrl.sv
// rtl/cpc_ram_paging_ctrl.sv - 512 KB RAM expansion paging controller for the CPC expansion bus
module cpc_ram_paging_ctrl (
    input  logic        CLK,
    input  logic        RESET_B,
    input  logic [15:0] A,
    input  logic [7:0]  D,
    input  logic        IOREQ_B,
    input  logic        MREQ_B,
    input  logic        WR_B,
    input  logic        RAMRD_B,
    output logic [18:0] sram_addr,
    output logic        sram_cs_b,
    output logic        sram_we_b,
    output logic        sram_oe_b,
    output logic        RAMDIS,
    output logic [5:0]  page_reg
);

    logic [2:0] mode_q, mode_d;
    logic [2:0] bank_q, bank_d;
    logic       paging_wr;
    logic [1:0] region;
    logic [1:0] blk;
    logic       exp_sel;

    // Only A15 is decoded for the paging port, so any OUT below &8000 with D[7:6]=11 hits it.
    assign paging_wr = ~IOREQ_B & ~WR_B & ~A[15] & (D[7:6] == 2'b11);

    always_comb begin
        mode_d = mode_q;
        bank_d = bank_q;
        if (paging_wr) begin
            mode_d = D[2:0];
            bank_d = D[5:3];
        end
    end

    always_ff @(posedge CLK or negedge RESET_B) begin
        if (!RESET_B) begin
            mode_q <= 3'd0;
            bank_q <= 3'd0;
        end else begin
            mode_q <= mode_d;
            bank_q <= bank_d;
        end
    end

    assign region = A[15:14];

    always_comb begin
        blk = 2'b00;
        if (mode_q[2]) begin
            blk = mode_q[1:0];
        end else begin
            blk[0] = mode_q[0] | (mode_q[1] & A[14]);
            blk[1] = mode_q[0] | (mode_q[1] & A[15]);
        end
    end

    // Raw address decode; MREQ_B only gates the write strobe, not the select.
    always_comb begin
        exp_sel = 1'b0;
        case (mode_q)
            3'b000:          exp_sel = 1'b0;
            3'b001, 3'b011:  exp_sel = (region == 2'b11);
            3'b010:          exp_sel = 1'b1;
            default:         exp_sel = (region == 2'b01);
        endcase
    end

    assign sram_addr = {bank_q, blk, A[13:0]};
    assign sram_cs_b = ~exp_sel;
    assign RAMDIS    = exp_sel;
    assign sram_we_b = WR_B | MREQ_B;
    assign sram_oe_b = RAMRD_B;
    assign page_reg  = {bank_q, mode_q};

endmodule

// File: tb/tb_cpc_ram_paging_ctrl.sv
// tb/tb_cpc_ram_paging_ctrl.sv - scoreboard bench for cpc_ram_paging_ctrl
module tb_cpc_ram_paging_ctrl;

    logic        CLK;
    logic        RESET_B;
    logic [15:0] A;
    logic [7:0]  D;
    logic        IOREQ_B, MREQ_B, WR_B, RAMRD_B;
    logic [18:0] sram_addr;
    logic        sram_cs_b, sram_we_b, sram_oe_b, RAMDIS;
    logic [5:0]  page_reg;

    cpc_ram_paging_ctrl dut (
        .CLK(CLK), .RESET_B(RESET_B), .A(A), .D(D),
        .IOREQ_B(IOREQ_B), .MREQ_B(MREQ_B), .WR_B(WR_B), .RAMRD_B(RAMRD_B),
        .sram_addr(sram_addr), .sram_cs_b(sram_cs_b), .sram_we_b(sram_we_b),
        .sram_oe_b(sram_oe_b), .RAMDIS(RAMDIS), .page_reg(page_reg)
    );

    typedef struct {
        string       tag;
        logic [5:0]  page;
        logic [18:0] addr;
        logic        cs_b;
        logic        we_b;
        logic        oe_b;
        logic        ramdis;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   model_page = 0;

    initial CLK = 1'b1;
    always #5 CLK = ~CLK;

    function automatic exp_t predict(string tag, int page, logic [15:0] a,
                                     logic mreq_b, logic wr_b, logic rd_b);
        exp_t e;
        int mode, bank, r, blk, offs;
        bit sel;
        mode = page % 8;
        bank = page / 8;
        r    = int'(a) / 16384;
        offs = int'(a) % 16384;
        case (mode)
            0:       begin blk = 0;        sel = 0;        end
            1, 3:    begin blk = 3;        sel = (r == 3); end
            2:       begin blk = r;        sel = 1;        end
            default: begin blk = mode - 4; sel = (r == 1); end
        endcase
        e.tag    = tag;
        e.page   = 6'(page);
        e.addr   = 19'(bank * 65536 + blk * 16384 + offs);
        e.cs_b   = !sel;
        e.ramdis = sel;
        e.we_b   = !(mreq_b == 1'b0 && wr_b == 1'b0);
        e.oe_b   = rd_b;
        return e;
    endfunction

    // One bus cycle: drive, predict with the current register, then apply the load rule at the edge.
    task automatic step(string tag, logic rst_b, logic [15:0] a, logic [7:0] d,
                        logic ioreq_b, logic mreq_b, logic wr_b, logic rd_b);
        RESET_B = rst_b; A = a; D = d;
        IOREQ_B = ioreq_b; MREQ_B = mreq_b; WR_B = wr_b; RAMRD_B = rd_b;
        if (!rst_b) model_page = 0;
        exp_q.push_back(predict(tag, model_page, a, mreq_b, wr_b, rd_b));
        @(posedge CLK);
        if (rst_b && !ioreq_b && !wr_b && a < 16'h8000 && d >= 8'hC0)
            model_page = int'(d) % 64;
        #1;
    endtask

    task automatic out_port(string tag, logic [15:0] a, logic [7:0] d);
        step(tag, 1'b1, a, d, 1'b0, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic mem_rd(string tag, logic [15:0] a);
        step(tag, 1'b1, a, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic chk(string tag, string field, logic [31:0] act, logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s.%s actual=%0h required=%0h", tag, field, act, req);
        end
    endtask

    always @(negedge CLK) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk(e.tag, "page_reg",  32'(page_reg),  32'(e.page));
            chk(e.tag, "sram_addr", 32'(sram_addr), 32'(e.addr));
            chk(e.tag, "sram_cs_b", 32'(sram_cs_b), 32'(e.cs_b));
            chk(e.tag, "RAMDIS",    32'(RAMDIS),    32'(e.ramdis));
            chk(e.tag, "sram_we_b", 32'(sram_we_b), 32'(e.we_b));
            chk(e.tag, "sram_oe_b", 32'(sram_oe_b), 32'(e.oe_b));
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ra;
        logic [7:0]  rd;
        int wait_cycles;

        step("rst_a4000", 1'b0, 16'h4000, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1);
        step("rst_ac000", 1'b0, 16'hC000, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
        step("idle",      1'b1, 16'h0000, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1);

        out_port("out_c4", 16'h7FFF, 8'hC4);
        mem_rd("c4_4000", 16'h4000);
        mem_rd("c4_8000", 16'h8000);

        out_port("out_ff", 16'h7FFF, 8'hFF);
        step("ff_wr4123", 1'b1, 16'h4123, 8'h55, 1'b1, 1'b0, 1'b0, 1'b1);

        out_port("out_da", 16'h7FFF, 8'hDA);
        mem_rd("da_0000", 16'h0000);
        mem_rd("da_4000", 16'h4000);
        mem_rd("da_8000", 16'h8000);
        mem_rd("da_c000", 16'hC000);

        out_port("out_c1", 16'h7FFF, 8'hC1);
        mem_rd("c1_c005", 16'hC005);
        mem_rd("c1_4000", 16'h4000);
        out_port("out_c3", 16'h7FFF, 8'hC3);
        mem_rd("c3_c005", 16'hC005);
        mem_rd("c3_4000", 16'h4000);

        out_port("out_ffff_c4", 16'hFFFF, 8'hC4);
        mem_rd("after_ffff", 16'h4000);
        out_port("out_7fff_84", 16'h7FFF, 8'h84);
        mem_rd("after_84", 16'h4000);
        step("memwr_c4", 1'b1, 16'h7FFF, 8'hC4, 1'b1, 1'b0, 1'b0, 1'b1);
        mem_rd("after_memwr", 16'h4000);

        out_port("out_c4_again", 16'h7FFF, 8'hC4);
        out_port("out_c4_repeat", 16'h7FFF, 8'hC4);
        step("mid_reset", 1'b0, 16'h4000, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1);
        mem_rd("post_reset", 16'h4000);

        for (int i = 0; i < 1500; i++) begin
            ra = 16'($urandom);
            if ($urandom_range(0, 1) == 0) ra[15] = 1'b0;
            rd = 8'($urandom);
            if ($urandom_range(0, 1) == 0) rd[7:6] = 2'b11;
            step("rand", ($urandom_range(0, 99) != 0), ra, rd,
                 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        end

        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 10) begin
            @(posedge CLK);
            wait_cycles++;
        end
        if (exp_q.size() > 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain actual=%0d required=0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
